memory_stage: RTL

Pipeline memory stage. It sits between execute and writeback, and it owns the data-memory request/acknowledge handshake. It formats load data (byte/half select, sign/zero extension) and store data/byte enables, and it flags misaligned or illegal accesses. It forwards pc, ALU result, memory data, wbsel and brtaken to the writeback stage as a one-cycle valid pulse per instruction.

---
 rtl/memory_stage.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Pipeline memory stage: owns the data-memory req/ack handshake, formats load/store lanes,
// flags misaligned/illegal accesses and emits one valid pulse per instruction to writeback.
module memory_stage #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] store_data_i,
    input  logic              memren_i,
    input  logic              memwen_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        wbsel_i,
    input  logic              brtaken_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ack_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] alu_res_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic [1:0]        wbsel_o,
    output logic              brtaken_o,
    output logic              fault_o
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    // Instruction context held across ACCESS.
    logic              ld_q, ld_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        sel_q, sel_d;
    logic [AWIDTH-1:0] pc_hold_q, pc_hold_d;
    logic [DWIDTH-1:0] alu_hold_q, alu_hold_d;
    logic [1:0]        wbsel_hold_q, wbsel_hold_d;
    logic              br_hold_q, br_hold_d;
    // Writeback payload, only updated when a valid pulse is produced.
    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] alu_q, alu_d;
    logic [DWIDTH-1:0] mdata_q, mdata_d;
    logic [1:0]        wbsel_q, wbsel_d;
    logic              br_q, br_d;
    logic              fault_q, fault_d;

    logic              mem_op, f3_legal, acc_fault;
    logic [3:0]        st_be;
    logic [DWIDTH-1:0] st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DWIDTH-1:0] ld_data;

    assign mem_op = memren_i | memwen_i;

    always_comb begin
        if (memren_i) begin
            f3_legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            f3_legal = funct3_i inside {3'b000, 3'b001, 3'b010};
        end
        acc_fault = mem_op && ((memren_i && memwen_i) || !f3_legal ||
                               ((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                               ((funct3_i[1:0] == 2'b10) && (alu_res_i[1:0] != 2'b00)));
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_res_i[1:0];
                st_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {alu_res_i[1], 1'b0};
                st_wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_i[{sel_q, 3'b000} +: 8];
        ld_half = sel_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        ld_d         = ld_q;
        f3_d         = f3_q;
        sel_d        = sel_q;
        pc_hold_d    = pc_hold_q;
        alu_hold_d   = alu_hold_q;
        wbsel_hold_d = wbsel_hold_q;
        br_hold_d    = br_hold_q;
        valid_d      = 1'b0;
        pc_d         = pc_q;
        alu_d        = alu_q;
        mdata_d      = mdata_q;
        wbsel_d      = wbsel_q;
        br_d         = br_q;
        fault_d      = fault_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    ld_d         = memren_i;
                    f3_d         = funct3_i;
                    sel_d        = alu_res_i[1:0];
                    pc_hold_d    = pc_i;
                    alu_hold_d   = alu_res_i;
                    wbsel_hold_d = wbsel_i;
                    br_hold_d    = brtaken_i;
                    if (!mem_op || acc_fault) begin
                        valid_d = 1'b1;
                        pc_d    = pc_i;
                        alu_d   = alu_res_i;
                        wbsel_d = wbsel_i;
                        br_d    = brtaken_i;
                        mdata_d = '0;
                        fault_d = acc_fault;
                    end else begin
                        state_d = StAccess;
                        req_d   = 1'b1;
                        we_d    = memwen_i;
                        addr_d  = {alu_res_i[AWIDTH-1:2], 2'b00};
                        wdata_d = memwen_i ? st_wdata : '0;
                        be_d    = memwen_i ? st_be : 4'b1111;
                    end
                end
            end
            StAccess: begin
                if (dmem_ack_i) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    pc_d    = pc_hold_q;
                    alu_d   = alu_hold_q;
                    wbsel_d = wbsel_hold_q;
                    br_d    = br_hold_q;
                    mdata_d = ld_q ? ld_data : '0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            ld_q         <= 1'b0;
            f3_q         <= 3'b000;
            sel_q        <= 2'b00;
            pc_hold_q    <= '0;
            alu_hold_q   <= '0;
            wbsel_hold_q <= 2'b00;
            br_hold_q    <= 1'b0;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            alu_q        <= '0;
            mdata_q      <= '0;
            wbsel_q      <= 2'b00;
            br_q         <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            ld_q         <= ld_d;
            f3_q         <= f3_d;
            sel_q        <= sel_d;
            pc_hold_q    <= pc_hold_d;
            alu_hold_q   <= alu_hold_d;
            wbsel_hold_q <= wbsel_hold_d;
            br_hold_q    <= br_hold_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            alu_q        <= alu_d;
            mdata_q      <= mdata_d;
            wbsel_q      <= wbsel_d;
            br_q         <= br_d;
            fault_q      <= fault_d;
        end
    end

    assign ready_o       = (state_q == StIdle);
    assign dmem_req_o    = req_q;
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_wdata_o  = wdata_q;
    assign dmem_be_o     = be_q;
    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign alu_res_o     = alu_q;
    assign memory_data_o = mdata_q;
    assign wbsel_o       = wbsel_q;
    assign brtaken_o     = br_q;
    assign fault_o       = fault_q;

endmodule
